prng_uniform_sampler: RTL

- Consumer-side controller for the 16-bit PRNG core.
- Drives the PRNG's seed-load and start/done handshake and reads each 16-bit word.
- Converts words to uniform coefficients mod Q by mask-and-reject sampling.
- Streams exactly N accepted coefficients per polynomial over a valid/ready port into the FHE accelerator's polynomial buffers.

---
 rtl/prng_uniform_sampler.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/prng_uniform_sampler.sv
//============================================================================
// Module      : prng_uniform_sampler
// Description : Consumer-side controller for a 16-bit PRNG core. It loads
//               seeds into the PRNG, runs the start/done handshake, and turns
//               each PRNG word into a uniform coefficient mod Q by
//               mask-and-reject sampling. It streams exactly N accepted
//               coefficients per polynomial over a valid/ready port.
//
// Ports       : clk, rst_n           - clock, asynchronous active-low reset
//               go, seed_load        - one-cycle command pulses (IDLE only)
//               seed_in              - seed captured on seed_load
//               prng_en/start/       - PRNG control outputs
//               loadseed/seed
//               prng_done/word       - PRNG result
//               coeff/coeff_idx/     - coefficient stream (valid/ready)
//               coeff_valid/ready
//               busy, poly_done      - status
//               reject_cnt           - saturating reject count since last go
//               timeout_err          - sticky WAIT timeout flag
//                                      (SAMPLER_TIMEOUT_EN builds only)
//
// Options     : `define SAMPLER_TIMEOUT_EN adds a timeout on prng_done in
//               WAIT, plus the timeout_err port.
//
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module prng_uniform_sampler #(
    parameter int N       = 256,
    parameter int Q       = 12289,
    parameter int MASK_W  = 14,
    parameter int IDX_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic             seed_load,
    input  logic [3:0]       seed_in,
    output logic             prng_en,
    output logic             prng_start,
    output logic             prng_loadseed,
    output logic [3:0]       prng_seed,
    input  logic             prng_done,
    input  logic [15:0]      prng_word,
    output logic [15:0]      coeff,
    output logic [IDX_W-1:0] coeff_idx,
    output logic             coeff_valid,
    input  logic             coeff_ready,
    output logic             busy,
    output logic             poly_done,
`ifdef SAMPLER_TIMEOUT_EN
    output logic             timeout_err,
`endif
    output logic [15:0]      reject_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEED  = 3'd1,
        S_REQ   = 3'd2,
        S_WAIT  = 3'd3,
        S_CHECK = 3'd4,
        S_OUT   = 3'd5,
        S_FIN   = 3'd6
    } state_t;

    localparam logic [MASK_W-1:0] Q_M      = MASK_W'(Q);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);
    localparam int                PAD_W    = 16 - MASK_W;

    state_t            state;
    logic [MASK_W-1:0] word_q;
    // Set when prng_done was already high during REQ; such a level belongs
    // to an earlier request and must drop before a new done is believed.
    logic              stale_done;

    // Bits above the mask are discarded by construction.
    logic              unused_word_hi;
    assign unused_word_hi = ^prng_word[15:MASK_W];

`ifdef SAMPLER_TIMEOUT_EN
    localparam int                TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT - 1);
    logic [TO_W-1:0] wait_cnt;
`else
    localparam int unused_timeout = TIMEOUT;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            word_q        <= '0;
            stale_done    <= 1'b0;
            prng_en       <= 1'b0;
            prng_start    <= 1'b0;
            prng_loadseed <= 1'b0;
            prng_seed     <= '0;
            coeff         <= '0;
            coeff_idx     <= '0;
            coeff_valid   <= 1'b0;
            busy          <= 1'b0;
            poly_done     <= 1'b0;
            reject_cnt    <= '0;
`ifdef SAMPLER_TIMEOUT_EN
            wait_cnt      <= '0;
            timeout_err   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    // seed_load has priority; a coincident go is dropped.
                    if (seed_load) begin
                        state         <= S_SEED;
                        prng_loadseed <= 1'b1;
                        prng_seed     <= seed_in;
                        busy          <= 1'b1;
                    end else if (go) begin
                        state      <= S_REQ;
                        coeff_idx  <= '0;
                        reject_cnt <= '0;
                        prng_en    <= 1'b1;
                        prng_start <= 1'b1;
                        busy       <= 1'b1;
`ifdef SAMPLER_TIMEOUT_EN
                        timeout_err <= 1'b0;
`endif
                    end
                end

                S_SEED: begin
                    state         <= S_IDLE;
                    prng_loadseed <= 1'b0;
                    prng_seed     <= '0;
                    busy          <= 1'b0;
                end

                S_REQ: begin
                    state      <= S_WAIT;
                    prng_start <= 1'b0;
                    stale_done <= prng_done;
`ifdef SAMPLER_TIMEOUT_EN
                    wait_cnt   <= '0;
`endif
                end

                S_WAIT: begin
                    if (prng_done && !stale_done) begin
                        word_q <= prng_word[MASK_W-1:0];
                        state  <= S_CHECK;
                    end else begin
                        if (!prng_done) begin
                            stale_done <= 1'b0;
                        end
`ifdef SAMPLER_TIMEOUT_EN
                        if (wait_cnt == TO_LAST) begin
                            state       <= S_IDLE;
                            timeout_err <= 1'b1;
                            prng_en     <= 1'b0;
                            busy        <= 1'b0;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
`endif
                    end
                end

                S_CHECK: begin
                    if (word_q < Q_M) begin
                        coeff       <= {{PAD_W{1'b0}}, word_q};
                        coeff_valid <= 1'b1;
                        state       <= S_OUT;
                    end else begin
                        if (reject_cnt != 16'hFFFF) begin
                            reject_cnt <= reject_cnt + 16'd1;
                        end
                        prng_start <= 1'b1;
                        state      <= S_REQ;
                    end
                end

                S_OUT: begin
                    if (coeff_ready) begin
                        coeff_valid <= 1'b0;
                        if (coeff_idx == LAST_IDX) begin
                            state     <= S_FIN;
                            poly_done <= 1'b1;
                            prng_en   <= 1'b0;
                            coeff_idx <= '0;
                        end else begin
                            coeff_idx  <= coeff_idx + 1'b1;
                            prng_start <= 1'b1;
                            state      <= S_REQ;
                        end
                    end
                end

                S_FIN: begin
                    poly_done <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
